// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with framing, parity and break detection
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int NUM_LEDS     = 3
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Busy,
    output logic [NUM_LEDS-1:0]  o_Led_N
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_HI
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic                 frame_err_q;

    logic                 baud_tick;
    logic                 frame_end;
    logic                 frame_err_all;
    logic                 data_xor;
    logic                 parity_bad;
    logic                 all_zero;

    assign baud_tick     = (cnt == LAST_CNT);
    assign frame_end     = (state == S_STOP) && baud_tick && (stop_idx == LAST_STOP);
    // The final stop bit is being sampled on the same edge the verdict is registered.
    assign frame_err_all = frame_err_q | ~rx_s;
    assign data_xor      = (^data_q) ^ par_q;
    assign parity_bad    = (PARITY_MODE == 1) ? ~data_xor :
                           (PARITY_MODE == 2) ?  data_xor : 1'b0;
    assign all_zero      = (data_q == '0) && ((PARITY_MODE == 0) || !par_q);

    assign o_Busy  = (state != S_IDLE);
    assign o_Led_N = ~o_Rx_Byte[NUM_LEDS-1:0];

    // Two-stage synchroniser for the asynchronous serial line.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start qualification, bit sequencing and break lockout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (cnt == HALF_CNT) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (baud_tick && (bit_idx == LAST_BIT))
                    state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (baud_tick) state_next = S_STOP;
            end
            S_STOP: begin
                if (frame_end) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = rx_s ? S_IDLE : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Baud counter, bit/stop indices and captured frame contents.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            data_q      <= '0;
            par_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if ((state == S_START) || (state == S_DATA) ||
                         (state == S_PARITY) || (state == S_STOP)) begin
                cnt <= baud_tick ? '0 : cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_idx     <= '0;
                        stop_idx    <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        data_q[bit_idx] <= rx_s;
                        bit_idx         <= bit_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_tick) par_q <= rx_s;
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (!rx_s) frame_err_q <= 1'b1;
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame verdict: pulses last exactly the one DONE cycle; the data word only moves on a clean frame.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_Rx_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Break      <= 1'b0;
            if (frame_end) begin
                o_Frame_Err  <= frame_err_all;
                o_Parity_Err <= parity_bad;
                o_Break      <= frame_err_all && all_zero;
                if (!frame_err_all && !parity_bad) begin
                    o_Rx_DV   <= 1'b1;
                    o_Rx_Byte <= data_q;
                end
            end
        end
    end

endmodule
